// File: rtl/ps2_rx_frontend.sv
// PS/2 keyboard receive front end: conditions ps2c/ps2d, deframes 11-bit
// frames, checks odd parity and stop, drops break sequences and delivers
// one make-code byte per key press as a single-cycle rx_valid pulse.
module ps2_rx_frontend #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter bit          SUPPRESS_BREAK = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [7:0]  BREAK_CODE = 8'hF0;

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  logic           c_s1, c_s2, d_s1, d_s2;
  logic           filt;
  logic [FCW-1:0] fcnt;
  logic           fall;

  state_t         state, state_n;
  logic [3:0]     bcnt, bcnt_n;
  logic [9:0]     shreg, shreg_n;
  logic [TCW-1:0] tcnt, tcnt_n;
  logic           break_pending, break_pending_n;
  logic [7:0]     rx_data_n;
  logic           rx_valid_n, frame_err_n, busy_n;

  logic [7:0]     frame_byte_c;
  logic           frame_good_c;

  assign frame_byte_c = shreg[7:0];
  // Odd parity over data+parity, and the stop bit must be high.
  assign frame_good_c = (^shreg[8:0]) & shreg[9];

  // Two-flop synchronisers for both asynchronous PS/2 lines (idle high).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_s1 <= 1'b1;
      c_s2 <= 1'b1;
      d_s1 <= 1'b1;
      d_s2 <= 1'b1;
    end else begin
      c_s1 <= ps2c;
      c_s2 <= c_s1;
      d_s1 <= ps2d;
      d_s2 <= d_s1;
    end
  end

  // Glitch filter: level flips only after FILTER_LEN consecutive opposite samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt <= 1'b1;
      fcnt <= '0;
      fall <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (c_s2 == filt) begin
        fcnt <= '0;
      end else if (fcnt == FCW'(FILTER_LEN - 1)) begin
        filt <= c_s2;
        fcnt <= '0;
        fall <= ~c_s2;
      end else begin
        fcnt <= fcnt + FCW'(1);
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bcnt          <= '0;
      shreg         <= '0;
      tcnt          <= '0;
      break_pending <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      frame_err     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      bcnt          <= bcnt_n;
      shreg         <= shreg_n;
      tcnt          <= tcnt_n;
      break_pending <= break_pending_n;
      rx_data       <= rx_data_n;
      rx_valid      <= rx_valid_n;
      frame_err     <= frame_err_n;
      busy          <= busy_n;
    end
  end

  // Next-state: deframing, watchdog, frame check and break suppression.
  always_comb begin
    state_n         = state;
    bcnt_n          = bcnt;
    shreg_n         = shreg;
    tcnt_n          = tcnt;
    break_pending_n = break_pending;
    rx_data_n       = rx_data;
    rx_valid_n      = 1'b0;
    frame_err_n     = 1'b0;

    case (state)
      IDLE: begin
        if (fall && !d_s2) begin
          state_n = SHIFT;
          bcnt_n  = '0;
          tcnt_n  = '0;
        end
      end
      SHIFT: begin
        // A fall always beats the watchdog on the same cycle.
        if (fall) begin
          shreg_n = {d_s2, shreg[9:1]};
          bcnt_n  = bcnt + 4'd1;
          tcnt_n  = '0;
          if (bcnt == 4'd9) state_n = CHECK;
        end else if (tcnt == TCW'(TIMEOUT_CYCLES - 1)) begin
          frame_err_n = 1'b1;
          tcnt_n      = '0;
          state_n     = IDLE;
        end else begin
          tcnt_n = tcnt + TCW'(1);
        end
      end
      CHECK: begin
        state_n = IDLE;
        if (!frame_good_c) begin
          frame_err_n = 1'b1;
        end else if (SUPPRESS_BREAK && (frame_byte_c == BREAK_CODE)) begin
          break_pending_n = 1'b1;
        end else if (break_pending) begin
          break_pending_n = 1'b0;
        end else begin
          rx_data_n  = frame_byte_c;
          rx_valid_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_ps2_rx_frontend.sv
// Directed bench for ps2_rx_frontend: two instances (break suppression on
// and off) share the PS/2 lines; a scoreboard queue per instance holds the
// expected delivery/error events, popped by a monitor on each pulse.
module tb_ps2_rx_frontend;

  localparam int L    = 8;
  localparam int T    = 1000;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic [7:0] rx_data0, rx_data1;
  logic       rx_valid0, rx_valid1, frame_err0, frame_err1, busy0, busy1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_drop = 0;
  int ev_cyc0 = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] last_m[2];
  bit         bp_m[2];
  logic [8:0] got0, exp0, got1, exp1;

  ps2_rx_frontend #(.FILTER_LEN(L), .TIMEOUT_CYCLES(T), .SUPPRESS_BREAK(1'b1)) dut (
    .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .frame_err(frame_err0), .busy(busy0));

  ps2_rx_frontend #(.FILTER_LEN(L), .TIMEOUT_CYCLES(T), .SUPPRESS_BREAK(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .frame_err(frame_err1), .busy(busy1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor for the break-suppressing instance.
  always @(negedge clk) begin
    if (!reset && (rx_valid0 || frame_err0)) begin
      got0 = frame_err0 ? 9'h100 : {1'b0, rx_data0};
      exp0 = (q0.size() != 0) ? q0.pop_front() : 9'h1FF;
      ev_cyc0 = cyc;
      check("event0", 32'(got0), 32'(exp0));
      check("excl0", 32'(rx_valid0 & frame_err0), 0);
    end
  end

  // Monitor for the pass-through instance.
  always @(negedge clk) begin
    if (!reset && (rx_valid1 || frame_err1)) begin
      got1 = frame_err1 ? 9'h100 : {1'b0, rx_data1};
      exp1 = (q1.size() != 0) ? q1.pop_front() : 9'h1FF;
      check("event1", 32'(got1), 32'(exp1));
      check("excl1", 32'(rx_valid1 & frame_err1), 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One PS/2 bit: data set while clock high, then clock low half period.
  task automatic ps2_bit(input bit b, input bit glitch);
    ps2d = b;
    if (glitch) begin
      tick(10);
      ps2c = 1'b0;
      tick(3);
      ps2c = 1'b1;
      tick(HALF - 13);
    end else begin
      tick(HALF);
    end
    ps2c = 1'b0;
    last_drop = cyc;
    tick(HALF);
    ps2c = 1'b1;
  endtask

  // Reference model: pushes expected events for both instances.
  task automatic expect_frame(input logic [7:0] b, input bit good, output bit ev0);
    logic [8:0] e;
    bit evt;
    ev0 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      evt = 1'b1;
      e = 9'h000;
      if (!good) e = 9'h100;
      else if (i == 0 && b == 8'hF0) begin bp_m[i] = 1'b1; evt = 1'b0; end
      else if (bp_m[i]) begin bp_m[i] = 1'b0; evt = 1'b0; end
      else begin e = {1'b0, b}; last_m[i] = b; end
      if (evt) begin
        if (i == 0) q0.push_back(e);
        else q1.push_back(e);
      end
      if (i == 0) ev0 = evt;
    end
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < bound) begin
      tick(1);
      n++;
    end
    check("drain0", q0.size(), 0);
    check("drain1", q1.size(), 0);
  endtask

  task automatic do_frame(input logic [7:0] b, input bit bad_par, input bit stop, input bit glitch);
    logic [10:0] fr;
    bit ev0;
    fr = {stop, (~^b) ^ bad_par, b, 1'b0};
    expect_frame(b, !bad_par && stop, ev0);
    for (int i = 0; i < 11; i++) ps2_bit(fr[i], glitch);
    ps2d = 1'b1;
    tick(HALF);
    wait_drain(200);
    if (ev0) check("latency", ev_cyc0 - last_drop, L + 4);
    check("data0", 32'(rx_data0), 32'(last_m[0]));
    check("data1", 32'(rx_data1), 32'(last_m[1]));
    check("busy0", 32'(busy0), 0);
    check("busy1", 32'(busy1), 0);
  endtask

  initial begin
    logic [10:0] fr;
    bit ev0;
    int lat;
    last_m[0] = 8'h00; last_m[1] = 8'h00;
    bp_m[0] = 1'b0; bp_m[1] = 1'b0;

    // Reset state.
    tick(4);
    check("rst_data", 32'(rx_data0), 0);
    check("rst_valid", 32'(rx_valid0), 0);
    check("rst_err", 32'(frame_err0), 0);
    check("rst_busy", 32'(busy0), 0);
    reset = 1'b0;
    tick(5);

    // Single make code.
    do_frame(8'h1C, 1'b0, 1'b1, 1'b0);

    // Press/release: suppressed on dut, three deliveries on dut_nb.
    do_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    do_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    do_frame(8'h1C, 1'b0, 1'b1, 1'b0);

    // Extended prefix passes through.
    do_frame(8'hE0, 1'b0, 1'b1, 1'b0);

    // Bad parity, then bad stop.
    do_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    do_frame(8'h1C, 1'b0, 1'b0, 1'b0);

    // Truncated frame: start + 4 data bits, then line idles.
    fr = {1'b1, ~^8'h5A, 8'h5A, 1'b0};
    expect_frame(8'h00, 1'b0, ev0);
    for (int i = 0; i < 5; i++) ps2_bit(fr[i], 1'b0);
    ps2d = 1'b1;
    check("tmo_busy", 32'(busy0), 1);
    wait_drain(T + 100);
    lat = ev_cyc0 - last_drop;
    check("tmo_lo", 32'(lat >= L + T + 2), 1);
    check("tmo_hi", 32'(lat <= L + T + 4), 1);
    check("tmo_idle", 32'(busy0), 0);
    do_frame(8'h32, 1'b0, 1'b1, 1'b0);

    // Short clock glitches between bits.
    do_frame(8'h45, 1'b0, 1'b1, 1'b1);

    // Reset after bit 5 of a frame.
    for (int i = 0; i < 6; i++) ps2_bit(fr[i], 1'b0);
    reset = 1'b1;
    #1;
    check("mid_rst_data", 32'(rx_data0), 0);
    check("mid_rst_valid", 32'(rx_valid0), 0);
    check("mid_rst_err", 32'(frame_err0), 0);
    check("mid_rst_busy", 32'(busy0), 0);
    check("mid_rst_data1", 32'(rx_data1), 0);
    last_m[0] = 8'h00; last_m[1] = 8'h00;
    bp_m[0] = 1'b0; bp_m[1] = 1'b0;
    ps2d = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(5);
    do_frame(8'h16, 1'b0, 1'b1, 1'b0);

    tick(20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
